// File: rtl/gate_truth_checker_if.sv
// Signal bundle between the gate truth checker and whatever drives it.
// The gate under test sits between gate_a/gate_b and gate_y.
interface gate_truth_checker_if;
  // Handshake: start is a request that is taken only on an IDLE edge and is
  // dropped silently otherwise; busy spans the accepted run, and done is a
  // single-cycle completion strobe after which pass/err_count/fail_vec are valid
  // and hold until the next accepted start.
  logic       start;
  logic [3:0] expect_tt;
  logic       gate_y;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [1:0] dbg_state;

  modport master (
    output start, expect_tt, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_vec, dbg_state
  );

  modport slave (
    input  start, expect_tt, gate_y,
    output gate_a, gate_b, busy, done, pass, err_count, fail_vec, dbg_state
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through vectors 00..11, holds each SETTLE+1 cycles,
// samples the gate output once per vector and scores it against a truth table.
module gate_truth_checker #(
  parameter int unsigned SETTLE = 2
) (
  input logic                 clk,
  input logic                 rst,
  gate_truth_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

  state_t     state, state_d;
  logic [1:0] vec, vec_d;
  logic [7:0] cnt, cnt_d;
  logic [3:0] exp_q, exp_d;
  logic       gate_a_q, gate_a_d;
  logic       gate_b_q, gate_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       mismatch;

  // Case inequality so an X or Z on the gate output is scored as a failure.
  always_comb begin
    mismatch = (bus.gate_y !== exp_q[vec]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    vec_d    = vec;
    cnt_d    = cnt;
    exp_d    = exp_q;
    gate_a_d = gate_a_q;
    gate_b_d = gate_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          exp_d    = bus.expect_tt;
          vec_d    = 2'd0;
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          cnt_d    = CNT_INIT;
          err_d    = 3'd0;
          fail_d   = 4'd0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (cnt == 8'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          fail_d[vec] = 1'b1;
          err_d       = err_q + 3'd1;
        end
        if (vec == 2'd3) begin
          state_d = FIN;
        end else begin
          vec_d    = vec + 2'd1;
          gate_a_d = vec_d[1];
          gate_b_d = vec_d[0];
          cnt_d    = CNT_INIT;
          state_d  = WAIT;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        // err_q already includes the last vector, scored on the CHECK edge.
        pass_d  = (err_q == 3'd0);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec      <= 2'd0;
      cnt      <= 8'd0;
      exp_q    <= 4'd0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      fail_q   <= 4'd0;
    end else begin
      vec      <= vec_d;
      cnt      <= cnt_d;
      exp_q    <= exp_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign bus.gate_a    = gate_a_q;
  assign bus.gate_b    = gate_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;
  assign bus.dbg_state = state;

endmodule
